// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide execute unit: 32-step shift-add multiply or restoring
// divide over one shared adder, with start/done handshake and pipeline stall.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic [XLEN-1:0] Result,
  output logic            done,
  output logic            busy,
  output logic            stall
);

  localparam int CW = $clog2(XLEN);
  localparam int AW = XLEN + 2;
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_result;
  logic            r_neg_res;
  logic            r_neg_rem;
  logic            r_done;

  // Operand decode at acceptance time
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div_zero;
  logic            w_div_ovf;

  assign w_is_div   = Funct3[2];
  assign w_a_signed = w_is_div ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
  assign w_b_signed = w_is_div ? ~Funct3[0] : ~Funct3[1];
  assign w_neg_a    = w_a_signed & SrcA[XLEN-1];
  assign w_neg_b    = w_b_signed & SrcB[XLEN-1];
  assign w_mag_a    = w_neg_a ? (~SrcA + XLEN'(1)) : SrcA;
  assign w_mag_b    = w_neg_b ? (~SrcB + XLEN'(1)) : SrcB;
  assign w_div_zero = w_is_div & (SrcB == '0);
  assign w_div_ovf  = w_is_div & ~Funct3[0] & (SrcA == MIN_INT) & (SrcB == '1);

  // Shared adder: add multiplicand for multiply, trial-subtract divisor for divide.
  // The extra top bit acts as the borrow flag of the trial subtraction.
  logic            w_op_div;
  logic [AW-1:0]   w_add_x;
  logic [AW-1:0]   w_add_y;
  logic [AW-1:0]   w_sum;
  logic            w_fits;

  assign w_op_div = r_funct3[2];
  assign w_add_x  = w_op_div ? {1'b0, r_hi, r_lo[XLEN-1]} : {2'b00, r_hi};
  assign w_add_y  = w_op_div ? {2'b00, r_b} : (r_lo[0] ? {2'b00, r_a} : '0);
  assign w_sum    = w_add_x + (w_add_y ^ {AW{w_op_div}}) + AW'(w_op_div);
  assign w_fits   = ~w_sum[AW-1];

  // Sign correction and result selection
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_fix_result;

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg_res ? (~w_prod + (2*XLEN)'(1)) : w_prod;
  assign w_quo_fix  = r_neg_res ? (~r_lo + XLEN'(1)) : r_lo;
  assign w_rem_fix  = r_neg_rem ? (~r_hi + XLEN'(1)) : r_hi;

  always_comb begin
    // NOTE: default assignment first so no path through the block leaves the output unassigned (no latch).
    w_fix_result = '0;
    case (r_funct3)
      3'b000:                 w_fix_result = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_result = w_quo_fix;
      default:                w_fix_result = w_rem_fix;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_funct3  <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_result  <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_funct3 <= Funct3;
              r_a      <= w_mag_a;
              r_b      <= w_mag_b;
              r_count  <= '0;
              // Special divides preload the final quotient/remainder and skip CALC.
              if (w_div_zero) begin
                r_hi      <= SrcA;
                r_lo      <= '1;
                r_neg_res <= 1'b0;
                r_neg_rem <= 1'b0;
                r_state   <= S_FIX;
              end else if (w_div_ovf) begin
                r_hi      <= '0;
                r_lo      <= MIN_INT;
                r_neg_res <= 1'b0;
                r_neg_rem <= 1'b0;
                r_state   <= S_FIX;
              end else begin
                r_hi      <= '0;
                r_lo      <= w_is_div ? w_mag_a : w_mag_b;
                r_neg_res <= w_neg_a ^ w_neg_b;
                r_neg_rem <= w_neg_a;
                r_state   <= S_CALC;
              end
            end
          end
          S_CALC: begin
            r_count <= r_count + CW'(1);
            if (w_op_div) begin
              if (w_fits) begin
                r_hi <= w_sum[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], 1'b1};
              end else begin
                r_hi <= {r_hi[XLEN-2:0], r_lo[XLEN-1]};
                r_lo <= {r_lo[XLEN-2:0], 1'b0};
              end
            end else begin
              {r_hi, r_lo} <= {w_sum[XLEN:0], r_lo[XLEN-1:1]};
            end
            if (r_count == LAST) begin
              r_state <= S_FIX;
            end
          end
          S_FIX: begin
            r_result <= w_fix_result;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign Result = r_result;
  assign done   = r_done;
  assign busy   = (r_state != S_IDLE);
  assign stall  = ((r_state == S_IDLE) & start & ~flush) | (r_state == S_CALC) | (r_state == S_FIX);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M vectors, randomized
// operations against an arithmetic reference model, flush, busy and reset cases.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  Funct3;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] Result;
  logic        done;
  logic        busy;
  logic        stall;

  int vectors     = 0;
  int miscompares = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Result (Result),
    .done   (done),
    .busy   (busy),
    .stall  (stall)
  );

  always #5 clk = ~clk;

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, q;
    longint unsigned ua, ub, p;
    logic [31:0]     r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin q = sa / sb; r = q[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin q = sa % sb; r = q[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // done cycle counted from the start cycle (cycle 0)
  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Issues one op from just after a rising edge; returns just after the edge following done.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res);
    int          lat;
    int          done_cyc;
    bit          hs_err;
    logic [31:0] res;
    lat      = ref_latency(f3, a, b);
    done_cyc = -1;
    hs_err   = 1'b0;
    res      = '0;
    Funct3 = f3; SrcA = a; SrcB = b; start = 1'b1; flush = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (!hs_err && (stall !== (c < lat) || busy !== (c >= 1) || done !== (c == lat))) begin
        hs_err = 1'b1;
        $display("FAIL %s handshake cycle %0d: stall=%b busy=%b done=%b, required stall=%b busy=%b done=%b",
                 name, c, stall, busy, done, c < lat, c >= 1, c == lat);
      end
      if (done === 1'b1) begin
        done_cyc = c;
        res      = Result;
      end
      @(posedge clk); #1;
      if (c == 0) begin
        start  = 1'b0;
        Funct3 = 3'($urandom_range(0, 7));
        SrcA   = $urandom;
        SrcB   = $urandom;
      end
      if (done_cyc >= 0) break;
    end
    vectors++;
    if (hs_err) miscompares++;
    vectors++;
    if (done_cyc != lat) begin
      miscompares++;
      $display("FAIL %s latency: done cycle %0d, required %0d", name, done_cyc, lat);
    end
    vectors++;
    if (res !== exp_res) begin
      miscompares++;
      $display("FAIL %s result: got %h, required %h", name, res, exp_res);
    end
    vectors++;
    if (Result !== exp_res) begin
      miscompares++;
      $display("FAIL %s result hold: got %h, required %h", name, Result, exp_res);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; flush = 1'b0;
    Funct3 = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({Result, done, busy, stall} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset outputs: Result=%h done=%b busy=%b stall=%b, required all 0",
               Result, done, busy, stall);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({done, busy, stall} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset release idle: done=%b busy=%b stall=%b, required 000", done, busy, stall);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op("MUL",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("MULH",     3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    run_op("MULHU",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("MULHSU",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("MUL zero", 3'd0, 32'd0,          32'd0,         32'd0);
    run_op("DIV",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    run_op("REM",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    run_op("DIVU",     3'd5, 32'd100,        32'd7,         32'd14);
    run_op("REMU",     3'd7, 32'd100,        32'd7,         32'd2);
    run_op("DIV by 0", 3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF);
    run_op("REM by 0", 3'd6, 32'd5,          32'd0,         32'd5);
    run_op("DIV ovf",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    run_op("REM ovf",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op($sformatf("rand%0d f3=%0d a=%h b=%h", i, f3, a, b), f3, a, b, ref_model(f3, a, b));
    end
  endtask

  task automatic test_flush();
    int first_done;
    run_op("flush pre DIVU", 3'd5, 32'd100, 32'd7, 32'd14);
    first_done = -1;
    Funct3 = 3'd4; SrcA = 32'hFFFF_FFF9; SrcB = 32'd2; start = 1'b1;
    for (int c = 0; c <= 60; c++) begin
      @(negedge clk);
      if (done === 1'b1 && first_done < 0) first_done = c;
      if (c == 11) begin
        vectors++;
        if (busy !== 1'b0 || first_done >= 0 || Result !== 32'd14) begin
          miscompares++;
          $display("FAIL flush abort: busy=%b done_seen=%0d Result=%h, required busy=0 none 0000000e",
                   busy, first_done, Result);
        end
      end
      @(posedge clk); #1;
      case (c + 1)
        1:  start = 1'b0;
        10: flush = 1'b1;
        11: begin flush = 1'b0; Funct3 = 3'd7; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1; end
        12: start = 1'b0;
        default: ;
      endcase
    end
    vectors++;
    if (first_done != 45 || Result !== 32'd2) begin
      miscompares++;
      $display("FAIL flush restart: done cycle %0d Result=%h, required 45 00000002", first_done, Result);
    end
    // start and flush together in IDLE: request dropped
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL start+flush stall: got %b, required 0", stall);
    end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL start+flush dropped: busy=%b done=%b, required 0 0", busy, done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore();
    int n_done;
    int done_cyc;
    n_done = 0; done_cyc = -1;
    Funct3 = 3'd5; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
    for (int c = 0; c <= 75; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge clk); #1;
      case (c + 1)
        1:  start = 1'b0;
        5:  begin start = 1'b1; Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd3; end
        35: start = 1'b0;
        default: ;
      endcase
    end
    vectors++;
    if (n_done != 1 || done_cyc != 34 || Result !== 32'd14) begin
      miscompares++;
      $display("FAIL busy ignore: dones=%0d first=%0d Result=%h, required 1 34 0000000e",
               n_done, done_cyc, Result);
    end
  endtask

  task automatic test_reset_midop();
    bit bad;
    bad = 1'b0;
    Funct3 = 3'd0; SrcA = $urandom; SrcB = $urandom; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({Result, done, busy, stall} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset midop: Result=%h done=%b busy=%b stall=%b, required all 0",
               Result, done, busy, stall);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL reset midop aftermath: done or busy seen high, required both 0");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_busy_ignore();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
